pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the CPU's 16-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands.
- The carry chain is split into STAGES registered segments, so the path meets timing at wider widths.
- Produces status flags (C, V, Z, N) for the ALU/flags register.
- Uses a valid/ready handshake with full-pipeline backpressure so the CPU datapath can stall it.

---
 rtl/pipelined_addsub.sv | 123 ++++++++++++
 tb/tb_pipelined_addsub.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with C/V/Z/N flags and valid/ready backpressure.
// Optional saturation on signed overflow is built when ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic adv;

  // Stage inputs: stage 0 comes from the ports, stage k from stage k-1's registers.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic [WIDTH-1:0] a_reg [STAGES];
  logic [WIDTH-1:0] b_reg [STAGES];
  logic [WIDTH-1:0] s_reg [STAGES];
  logic             c_reg [STAGES];
  logic             v_reg [STAGES];

  // The whole pipe moves only when the output slot is empty or being drained.
  assign adv      = !v_reg[LAST] || out_ready;
  assign in_ready = rst_n && adv;

  always_comb begin
    a_in[0] = A;
    b_in[0] = B ^ {WIDTH{sub}};
    s_in[0] = '0;
    c_in[0] = sub;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_reg[k-1];
      b_in[k] = b_reg[k-1];
      s_in[k] = s_reg[k-1];
      c_in[k] = c_reg[k-1];
      v_in[k] = v_reg[k-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] s_next;

      assign seg_sum = {1'b0, a_in[gi][gi*SEG +: SEG]}
                     + {1'b0, b_in[gi][gi*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_in[gi]};

      // Lower slices already resolved ride along; this stage fills in its own slice.
      always_comb begin
        s_next = s_in[gi];
        s_next[gi*SEG +: SEG] = seg_sum[SEG-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg[gi] <= '0;
          b_reg[gi] <= '0;
          s_reg[gi] <= '0;
          c_reg[gi] <= 1'b0;
          v_reg[gi] <= 1'b0;
        end else if (adv) begin
          a_reg[gi] <= a_in[gi];
          b_reg[gi] <= b_in[gi];
          s_reg[gi] <= s_next;
          c_reg[gi] <= seg_sum[SEG];
          v_reg[gi] <= v_in[gi];
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] final_sum;
  logic             raw_carry;
  logic             msb_cin;
  logic             ovf;

  assign raw_sum   = s_reg[LAST];
  assign raw_carry = c_reg[LAST];
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign msb_cin   = a_reg[LAST][WIDTH-1] ^ b_reg[LAST][WIDTH-1] ^ raw_sum[WIDTH-1];
  assign ovf       = msb_cin ^ raw_carry;

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = (WIDTH)'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;

  // On overflow the wrapped sign is the inverse of the true sign.
  assign final_sum = ovf ? (raw_sum[WIDTH-1] ? SMAX : SMIN) : raw_sum;
`else
  assign final_sum = raw_sum;
`endif

  assign out_valid = v_reg[LAST];
  assign result    = out_valid ? final_sum : '0;
  assign CarryOut  = out_valid & raw_carry;
  assign Overflow  = out_valid & ovf;
  assign Zero      = out_valid & (final_sum == '0);
  assign Negative  = out_valid & final_sum[WIDTH-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4), randomized against
// an arithmetic reference model; honours ADDSUB_SAT_EN when defined.
module tb_pipelined_addsub;

  localparam int W  = 16;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          CarryOut, Overflow, Zero, Negative;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero),
    .Negative(Negative)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        v;
    logic [19:0] d;
  } ent_t;

  ent_t        exp_q[$];   // model of in-flight slots, index 0 = output slot
  logic [15:0] got_q[$];   // results actually transferred out of the DUT
  logic [19:0] got_vec;

  assign got_vec = {result, CarryOut, Overflow, Zero, Negative};

  // Reference: plain integer arithmetic, returns {result, C, V, Z, N}.
  function automatic logic [19:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    int          ts;
    logic [15:0] r;
    logic        c, v;
    if (s) begin
      ts = int'($signed(a)) - int'($signed(b));
      r  = a - b;
      c  = (a >= b);
    end else begin
      ts = int'($signed(a)) + int'($signed(b));
      r  = a + b;
      c  = (int'(a) + int'(b)) > 65535;
    end
    v = (ts > 32767) || (ts < -32768);
`ifdef ADDSUB_SAT_EN
    if (v) r = (ts > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {r, c, v, (r == 16'h0000), r[15]};
  endfunction

  task automatic model_reset;
    exp_q.delete();
    repeat (ST) exp_q.push_back('0);
  endtask

  // Drive one cycle, advance the model, then wait until just after the clock edge.
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic ordy, output logic acc);
    ent_t e;
    in_valid = iv; A = a; B = b; sub = s; out_ready = ordy;
    #1;
    if (out_valid && out_ready) got_q.push_back(result);
    acc = 1'b0;
    if (!exp_q[0].v || ordy) begin
      e.v = iv;
      e.d = iv ? ref_op(a, b, s) : 20'h0;
      void'(exp_q.pop_front());
      exp_q.push_back(e);
      acc = iv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    in_valid = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, got_vec} !== 21'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b data=%h required v=0 data=00000", out_valid, got_vec);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got in_ready=%0b out_valid=%0b required in_ready=1 out_valid=0", in_ready, out_valid);
    end
    model_reset();
  endtask

  task automatic test_directed;
    logic [15:0] ta [4] = '{16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000};
    logic [15:0] tb [4] = '{16'h0001, 16'h0007, 16'h0001, 16'h0001};
    logic        ts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
    logic [19:0] te [4] = '{{16'h0000, 4'b1010}, {16'hFFFE, 4'b0001},
                            {16'h7FFF, 4'b0100}, {16'h8000, 4'b1101}};
`else
    logic [19:0] te [4] = '{{16'h0000, 4'b1010}, {16'hFFFE, 4'b0001},
                            {16'h8000, 4'b0101}, {16'h7FFF, 4'b1100}};
`endif
    logic acc;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ta[i], tb[i], ts[i], 1'b1, acc);
      for (int t = 1; t < ST; t++) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL directed%0d_early cycle %0d: got out_valid=%0b required 0", i, t, out_valid);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
      end
      checks++;
      if (out_valid !== 1'b1 || got_vec !== te[i]) begin
        failures++;
        $display("FAIL directed%0d: got v=%0b res=%h cvzn=%b required v=1 res=%h cvzn=%b",
                 i, out_valid, got_vec[19:4], got_vec[3:0], te[i][19:4], te[i][3:0]);
      end
    end
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
  endtask

  task automatic test_stream;
    logic [15:0] exp_r[$];
    logic [19:0] snap;
    logic        snap_v, ordy, acc, stall;
    int          idx = 0;
    int          c = 0;
    for (int i = 0; i < 8; i++) begin
      logic [19:0] rr;
      rr = ref_op(16'(i * 'h1111), 16'h0101, i[0]);
      exp_r.push_back(rr[19:4]);
    end
    got_q.delete();
    snap = got_vec; snap_v = out_valid;
    while (c < 40 && (idx < 8 || exp_q[0].v || exp_q[1].v || exp_q[2].v || exp_q[3].v)) begin
      ordy = !(c >= 5 && c <= 7);
      out_ready = ordy;
      #1;
      checks++;
      if (in_ready !== (!exp_q[0].v || ordy) || ((c >= 5 && c <= 7) && in_ready !== 1'b0)) begin
        failures++;
        $display("FAIL stream_in_ready cycle %0d: got %0b required %0b", c, in_ready, !exp_q[0].v || ordy);
      end
      stall = snap_v && !ordy;
      step(idx < 8, 16'(idx * 'h1111), 16'h0101, idx[0], ordy, acc);
      if (acc) idx++;
      checks++;
      if (out_valid !== exp_q[0].v || (exp_q[0].v && got_vec !== exp_q[0].d)) begin
        failures++;
        $display("FAIL stream_out cycle %0d: got v=%0b data=%h required v=%0b data=%h",
                 c, out_valid, got_vec, exp_q[0].v, exp_q[0].d);
      end
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || got_vec !== snap) begin
          failures++;
          $display("FAIL stream_hold cycle %0d: got v=%0b data=%h required v=1 data=%h", c, out_valid, got_vec, snap);
        end
      end
      snap = got_vec; snap_v = out_valid;
      c++;
    end
    checks++;
    if (got_q.size() != 8) begin
      failures++;
      $display("FAIL stream_count: got %0d results required 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_r[i]) begin
        failures++;
        $display("FAIL stream_order item %0d: got %h required %h", i, got_q[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] corner [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] a, b;
    logic        ordy, acc;
    for (int c = 0; c < 300; c++) begin
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      out_ready = ordy;
      #1;
      checks++;
      if (in_ready !== (!exp_q[0].v || ordy)) begin
        failures++;
        $display("FAIL random_in_ready cycle %0d: got %0b required %0b", c, in_ready, !exp_q[0].v || ordy);
      end
      step($urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)), ordy, acc);
      checks++;
      if (out_valid !== exp_q[0].v || (exp_q[0].v && got_vec !== exp_q[0].d)) begin
        failures++;
        $display("FAIL random_out cycle %0d: got v=%0b data=%h required v=%0b data=%h",
                 c, out_valid, got_vec, exp_q[0].v, exp_q[0].d);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic acc;
    for (int i = 0; i < 6; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_full: got out_valid=%0b required 1", out_valid);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, got_vec} !== 21'h0) begin
      failures++;
      $display("FAIL mid_async_clear: got v=%0b data=%h required v=0 data=00000", out_valid, got_vec);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, acc);
    step(1'b1, 16'h3333, 16'h0001, 1'b1, 1'b1, acc);
    step(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1, acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, got_vec} !== 21'h0) begin
      failures++;
      $display("FAIL reset_cycle2: got v=%0b data=%h required v=0 data=00000", out_valid, got_vec);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_stale cycle %0d: got out_valid=%0b required 0", t, out_valid);
      end
    end
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, acc);
    for (int t = 1; t < ST; t++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_early cycle %0d: got out_valid=%0b required 0", t, out_valid);
      end
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    end
    checks++;
    if (out_valid !== 1'b1 || got_vec !== {16'h5555, 4'b0000}) begin
      failures++;
      $display("FAIL post_reset_op: got v=%0b res=%h cvzn=%b required v=1 res=5555 cvzn=0000",
               out_valid, got_vec[19:4], got_vec[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
